// File: rtl/rtc_bus_pkg.sv
// Shared constants and types for the RTC bus responder: register map, BCD limits, bus FSM states.
package rtc_bus_pkg;

   localparam logic [7:0] ADDR_SEG  = 8'h00;
   localparam logic [7:0] ADDR_MIN  = 8'h01;
   localparam logic [7:0] ADDR_HORA = 8'h02;

   localparam logic [7:0] BCD_LIM_MS   = 8'h59;
   localparam logic [7:0] BCD_LIM_HORA = 8'h23;

   typedef enum logic {IDLE, DRIVE} state_t;

endpackage

// File: rtl/bcd_inc.sv
// Per-nibble BCD incrementer: wraps to 0x00 with carry at the limit, otherwise
// a low nibble of 9 or more rolls into the high nibble; no other correction.
module bcd_inc (
   input  logic [7:0] value,
   input  logic [7:0] limit,
   output logic [7:0] value_next,
   output logic       carry
);

   always_comb begin
      carry      = 1'b0;
      value_next = value;
      if (value == limit) begin
         carry      = 1'b1;
         value_next = 8'h00;
      end else if (value[3:0] >= 4'd9) begin
         value_next = {value[7:4] + 4'd1, 4'h0};
      end else begin
         value_next = {value[7:4], value[3:0] + 4'd1};
      end
   end

endmodule

// File: rtl/rtc_bus_responder.sv
// Device-side responder for the multiplexed RTC address/data bus: synchronizes host
// strobes, holds a small register file with BCD timekeeping, and drives read data back.
//
// state | meaning
// IDLE  | dato released, waiting for a data-phase read strobe
// DRIVE | dato driven with the snapshot taken on entry
module rtc_bus_responder
   import rtc_bus_pkg::*;
#(
   parameter int N_REGS      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs_n,
   input  logic       a_d,
   input  logic       rd_n,
   input  logic       wr_n,
   inout  wire  [7:0] dato,
   input  logic       sec_tick,
   output logic [7:0] out_seg,
   output logic [7:0] out_min,
   output logic [7:0] out_hora,
   output logic       out_drive
);

   localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam logic [8:0]    N_REGS_W = 9'(N_REGS);
   localparam logic [AW-1:0] IDX_SEG  = AW'(ADDR_SEG);
   localparam logic [AW-1:0] IDX_MIN  = AW'(ADDR_MIN);
   localparam logic [AW-1:0] IDX_HORA = AW'(ADDR_HORA);

   logic [SYNC_STAGES-1:0] cs_sh, ad_sh, rd_sh, wr_sh;
   logic [7:0]             d_sh [SYNC_STAGES];
   logic                   cs_s, ad_s, rd_s, wr_s;
   logic [7:0]             d_s;
   logic                   rd_prev, wr_prev, wr_conflict;
   logic                   rd_fall, wr_rise, host_wr, addr_wr, data_wr, rd_start;

   logic [7:0]    regs [N_REGS];
   logic [7:0]    addr_reg;
   logic [AW-1:0] idx;
   logic          in_range;
   logic [7:0]    rd_data;

   logic [7:0] seg_next, min_next, hora_next;
   logic       seg_carry, min_carry, hora_carry;

   state_t state, state_nx;
   logic   drive_en;

   // All bus inputs share the same depth so strobes and data stay aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_sh       <= '1;
         ad_sh       <= '0;
         rd_sh       <= '1;
         wr_sh       <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) d_sh[i] <= 8'h00;
         rd_prev     <= 1'b1;
         wr_prev     <= 1'b1;
         wr_conflict <= 1'b0;
      end else begin
         cs_sh   <= {cs_sh[SYNC_STAGES-2:0], cs_n};
         ad_sh   <= {ad_sh[SYNC_STAGES-2:0], a_d};
         rd_sh   <= {rd_sh[SYNC_STAGES-2:0], rd_n};
         wr_sh   <= {wr_sh[SYNC_STAGES-2:0], wr_n};
         d_sh[0] <= dato;
         for (int i = 1; i < SYNC_STAGES; i++) d_sh[i] <= d_sh[i-1];
         rd_prev <= rd_s;
         wr_prev <= wr_s;
         // A write strobe that overlapped a read strobe is poisoned until it ends.
         if (!wr_s && !rd_s)
            wr_conflict <= 1'b1;
         else if (wr_s)
            wr_conflict <= 1'b0;
      end
   end

   assign cs_s = cs_sh[SYNC_STAGES-1];
   assign ad_s = ad_sh[SYNC_STAGES-1];
   assign rd_s = rd_sh[SYNC_STAGES-1];
   assign wr_s = wr_sh[SYNC_STAGES-1];
   assign d_s  = d_sh[SYNC_STAGES-1];

   assign rd_fall  = rd_prev & ~rd_s;
   assign wr_rise  = wr_s & ~wr_prev;
   assign host_wr  = wr_rise & ~cs_s & rd_s & ~wr_conflict;
   assign addr_wr  = host_wr & ~ad_s;
   assign in_range = {1'b0, addr_reg} < N_REGS_W;
   assign idx      = addr_reg[AW-1:0];
   assign data_wr  = host_wr & ad_s & in_range;
   assign rd_start = rd_fall & ~cs_s & ad_s & wr_s;

   always_ff @(posedge clk) begin
      if (reset)
         addr_reg <= 8'h00;
      else if (addr_wr)
         addr_reg <= d_s;
   end

   bcd_inc u_inc_seg (
      .value(regs[IDX_SEG]), .limit(BCD_LIM_MS), .value_next(seg_next), .carry(seg_carry)
   );
   bcd_inc u_inc_min (
      .value(regs[IDX_MIN]), .limit(BCD_LIM_MS), .value_next(min_next), .carry(min_carry)
   );
   bcd_inc u_inc_hora (
      .value(regs[IDX_HORA]), .limit(BCD_LIM_HORA), .value_next(hora_next), .carry(hora_carry)
   );

   // Host write is assigned last so it overrides the tick on the same field;
   // carries were computed from the pre-write values and still propagate.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_REGS; i++) regs[i] <= 8'h00;
      end else begin
         if (sec_tick) begin
            regs[IDX_SEG] <= seg_next;
            if (seg_carry) begin
               regs[IDX_MIN] <= min_next;
               if (min_carry) regs[IDX_HORA] <= hora_next;
            end
         end
         if (data_wr) regs[idx] <= d_s;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (rd_start) state_nx = DRIVE;
         DRIVE:   if (rd_s || cs_s || !wr_s) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      drive_en = 1'b0;
      case (state)
         DRIVE:   drive_en = 1'b1;
         default: drive_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         rd_data <= 8'h00;
      else if (state == IDLE && rd_start)
         rd_data <= in_range ? regs[idx] : 8'h00;
   end

   assign dato      = drive_en ? rd_data : 8'hzz;
   assign out_drive = drive_en;
   assign out_seg   = regs[IDX_SEG];
   assign out_min   = regs[IDX_MIN];
   assign out_hora  = regs[IDX_HORA];

   logic unused_ok;
   assign unused_ok = hora_carry;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: directed bus cycles plus a randomized mix of
// writes, reads and ticks, all compared against a register-level model.
module tb_rtc_bus_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic       cs_n, a_d, rd_n, wr_n, sec_tick;
   logic [7:0] host_d;
   logic       host_oe;
   wire  [7:0] dato;
   logic [7:0] out_seg, out_min, out_hora;
   logic       out_drive;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_regs [16];
   logic [7:0] m_addr;

   assign dato = host_oe ? host_d : 8'hzz;

   always #5 clk = ~clk;

   rtc_bus_responder #(.N_REGS(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .cs_n(cs_n), .a_d(a_d), .rd_n(rd_n), .wr_n(wr_n),
      .dato(dato), .sec_tick(sec_tick), .out_seg(out_seg), .out_min(out_min),
      .out_hora(out_hora), .out_drive(out_drive)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Time-of-day model: per-nibble increment, wrap to zero at the field limit.
   task automatic m_inc(input logic [7:0] v, input logic [7:0] lim,
                        output logic [7:0] nv, output logic c);
      int hi, lo;
      c  = 1'b0;
      hi = int'(v) / 16;
      lo = int'(v) % 16;
      if (v == lim) begin
         nv = 8'h00;
         c  = 1'b1;
      end else begin
         if (lo >= 9) begin
            lo = 0;
            hi = (hi + 1) % 16;
         end else begin
            lo = lo + 1;
         end
         nv = 8'(hi * 16 + lo);
      end
   endtask

   task automatic m_tick();
      logic [7:0] s, m, h;
      logic       cs, cm, ch;
      m_inc(m_regs[0], 8'h59, s, cs);
      m_inc(m_regs[1], 8'h59, m, cm);
      m_inc(m_regs[2], 8'h23, h, ch);
      m_regs[0] = s;
      if (cs) begin
         m_regs[1] = m;
         if (cm) m_regs[2] = h;
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_addr = 8'h00;
   endtask

   function automatic logic [7:0] m_rd();
      logic [3:0] k;
      k = m_addr[3:0];
      return (m_addr < 8'd16) ? m_regs[k] : 8'h00;
   endfunction

   task automatic bus_write(input logic ad, input logic [7:0] d, input logic tick);
      @(negedge clk);
      cs_n = 1'b0; a_d = ad; host_d = d; host_oe = 1'b1;
      @(negedge clk) wr_n = 1'b0;
      repeat (4) @(negedge clk);
      wr_n = 1'b1;
      @(negedge clk);
      @(negedge clk) if (tick) sec_tick = 1'b1;
      @(negedge clk);
      sec_tick = 1'b0; cs_n = 1'b1; host_oe = 1'b0;
      repeat (2) @(negedge clk);
      if (tick) m_tick();
      if (!ad) m_addr = d;
      else if (m_addr < 8'd16) m_regs[m_addr[3:0]] = d;
   endtask

   task automatic bus_read(input string tag, input logic [7:0] exp, input logic tick_mid);
      @(negedge clk);
      cs_n = 1'b0; a_d = 1'b1;
      @(negedge clk) rd_n = 1'b0;
      repeat (2) @(negedge clk);
      chk({tag, "_early"}, {7'b0, out_drive}, 8'h00);
      @(negedge clk);
      chk({tag, "_drv"}, {7'b0, out_drive}, 8'h01);
      if (tick_mid) sec_tick = 1'b1;
      @(negedge clk) sec_tick = 1'b0;
      @(negedge clk);
      chk({tag, "_data"}, dato, exp);
      rd_n = 1'b1;
      repeat (2) @(negedge clk);
      chk({tag, "_hold"}, {7'b0, out_drive}, 8'h01);
      @(negedge clk);
      chk({tag, "_rel"}, {7'b0, out_drive}, 8'h00);
      cs_n = 1'b1;
      repeat (2) @(negedge clk);
      if (tick_mid) m_tick();
   endtask

   task automatic tick_pulse();
      @(negedge clk) sec_tick = 1'b1;
      @(negedge clk) sec_tick = 1'b0;
      m_tick();
      chk("tick_seg", out_seg, m_regs[0]);
      chk("tick_min", out_min, m_regs[1]);
      chk("tick_hora", out_hora, m_regs[2]);
   endtask

   task automatic scan_all(input string tag);
      for (int i = 0; i < 16; i++) begin
         bus_write(1'b0, 8'(i), 1'b0);
         bus_read(tag, m_rd(), 1'b0);
      end
   endtask

   initial begin
      logic seen;
      int   op;
      reset = 1'b1; cs_n = 1'b1; a_d = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
      sec_tick = 1'b0; host_d = 8'h00; host_oe = 1'b0;
      m_reset();
      repeat (3) @(negedge clk);
      chk("rst_drive", {7'b0, out_drive}, 8'h00);
      chk("rst_seg", out_seg, 8'h00);
      chk("rst_min", out_min, 8'h00);
      chk("rst_hora", out_hora, 8'h00);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      bus_write(1'b0, 8'h05, 1'b0);
      bus_write(1'b1, 8'hA7, 1'b0);
      bus_read("wr_rd", m_rd(), 1'b0);
      chk("wr_rd_const", m_rd(), 8'hA7);

      bus_write(1'b0, 8'h02, 1'b0); bus_write(1'b1, 8'h23, 1'b0);
      bus_write(1'b0, 8'h01, 1'b0); bus_write(1'b1, 8'h59, 1'b0);
      bus_write(1'b0, 8'h00, 1'b0); bus_write(1'b1, 8'h59, 1'b0);
      tick_pulse();
      chk("rollover_all", {out_hora | out_min | out_seg}, 8'h00);

      bus_write(1'b1, 8'h12, 1'b0);
      bus_write(1'b1, 8'h30, 1'b1);
      chk("collide_seg", out_seg, 8'h30);

      bus_write(1'b1, 8'h59, 1'b0);
      bus_write(1'b0, 8'h01, 1'b0); bus_write(1'b1, 8'h10, 1'b0);
      bus_write(1'b0, 8'h00, 1'b0); bus_write(1'b1, 8'h05, 1'b1);
      chk("collide_carry_seg", out_seg, m_regs[0]);
      chk("collide_carry_min", out_min, m_regs[1]);

      bus_write(1'b1, 8'h3A, 1'b0);
      tick_pulse();
      bus_read("tick_in_drive", m_rd(), 1'b1);
      chk("tick_in_drive_seg", out_seg, m_regs[0]);

      @(negedge clk);
      cs_n = 1'b0; a_d = 1'b0; seen = 1'b0;
      @(negedge clk) rd_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_drive) seen = 1'b1;
         if (i == 5) rd_n = 1'b1;
      end
      cs_n = 1'b1;
      chk("addr_phase_read", {7'b0, seen}, 8'h00);

      bus_write(1'b0, 8'h04, 1'b0);
      bus_write(1'b1, 8'h66, 1'b0);
      @(negedge clk);
      cs_n = 1'b0; a_d = 1'b1; host_d = 8'hEE; host_oe = 1'b1; seen = 1'b0;
      @(negedge clk) begin rd_n = 1'b0; wr_n = 1'b0; end
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (out_drive) seen = 1'b1;
         if (i == 5) begin rd_n = 1'b1; wr_n = 1'b1; end
      end
      cs_n = 1'b1; host_oe = 1'b0;
      chk("dual_low_drive", {7'b0, seen}, 8'h00);
      scan_all("dual_low_scan");

      bus_write(1'b0, 8'h20, 1'b0);
      bus_write(1'b1, 8'h99, 1'b0);
      bus_read("oor_read", m_rd(), 1'b0);
      chk("oor_const", m_rd(), 8'h00);

      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 9));
         if (op <= 2) bus_write(1'b0, 8'($urandom_range(0, 19)), 1'b0);
         else if (op <= 5) bus_write(1'b1, 8'($urandom), 1'b0);
         else if (op <= 7) bus_read("rand_read", m_rd(), 1'b0);
         else tick_pulse();
      end
      scan_all("rand_scan");

      bus_write(1'b0, 8'h05, 1'b0);
      bus_write(1'b1, 8'h5C, 1'b0);
      @(negedge clk);
      cs_n = 1'b0; a_d = 1'b1;
      @(negedge clk) rd_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_rst_drv", {7'b0, out_drive}, 8'h01);
      chk("mid_rst_data", dato, 8'h5C);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_rel", {7'b0, out_drive}, 8'h00);
      rd_n = 1'b1; cs_n = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      chk("post_rst_seg", out_seg, 8'h00);
      scan_all("post_rst_scan");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Device-side responder for the multiplexed 8-bit RTC address/data bus that the FPGA host drives through its tri-state bus logic. It decodes address and data phases from the host strobes, holds a 16-entry register file, and drives read data back onto the shared bus. It also keeps a BCD seconds/minutes/hours count advanced by a one-second tick. It serves as the synthesizable stand-in for the RTC chip in board-less bring-up and as the reference responder in host-side benches.

## Interface
Parameters:
- N_REGS, 16: register file depth; the low log2(N_REGS) address bits are decoded.
- SYNC_STAGES, 2: synchronizer depth on all bus inputs.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- cs_n  in  1  chip select, active-low.
- a_d  in  1  phase select: 0 = address phase, 1 = data phase.
- rd_n  in  1  read strobe, active-low.
- wr_n  in  1  write strobe, active-low.
- dato  inout  8  shared address/data bus, tri-stated when not driving.
- sec_tick  in  1  one-cycle pulse, once per second.
- out_seg  out  8  BCD seconds (register 0x00).
- out_min  out  8  BCD minutes (register 0x01).
- out_hora  out  8  BCD hours, 24 h (register 0x02).
- out_drive  out  1  high while the block drives dato.

## Operation
- Synchronization: cs_n, a_d, rd_n, wr_n and dato each pass through SYNC_STAGES flops in parallel, so strobe and data stay aligned. All decoding uses the synchronized copies.
- Address latch: on a synchronized wr_n rising edge with cs_n=0 and a_d=0, addr_reg <= dato.
- Data write:
  - On a synchronized wr_n rising edge with cs_n=0 and a_d=1, regs[addr_reg] <= dato.
  - If addr_reg >= N_REGS, the write is discarded.
- FSM states:
  - IDLE: dato is high-Z. Go to DRIVE on a synchronized rd_n falling edge with cs_n=0, a_d=1 and wr_n=1. On that transition, rd_data <= regs[addr_reg], or 0x00 if addr_reg is out of range.
  - DRIVE: dato = rd_data and out_drive = 1. Return to IDLE when synchronized rd_n=1, cs_n=1 or wr_n=0 (bus contention).
- Read with a_d=0 (address read): ignored. The block stays in IDLE and does not drive.
- rd_n and wr_n both low: no drive and no write. An in-progress DRIVE aborts to IDLE.
- Timekeeping on sec_tick:
  - Seconds increment in BCD, 0x59 -> 0x00, with a carry to minutes.
  - Minutes wrap 0x59 -> 0x00 with a carry to hours.
  - Hours wrap 0x23 -> 0x00.
  - A non-BCD value written by the host is incremented by the same rule per nibble. A low nibble of 9 or more rolls to 0 and carries into the high nibble. No other correction is applied.
- Simultaneous host write and tick on the same register in the same cycle: the host write wins and the tick for that field is dropped. Carries into other fields still apply.
- Registers 0x03..N_REGS-1 are plain read/write storage.

## Timing
- Reset: all regs, addr_reg and rd_data are 0x00; FSM is in IDLE; dato is high-Z; out_drive=0; out_seg, out_min and out_hora are 0x00; synchronizers are cleared to the idle levels (strobes and cs_n = 1).
- Write latency: the register updates SYNC_STAGES+1 cycles after the wr_n rising edge at the pins.
- Read latency: dato is driven SYNC_STAGES+1 cycles after the rd_n falling edge. The host must hold rd_n low for at least SYNC_STAGES+3 cycles before sampling.
- Release: dato goes high-Z SYNC_STAGES+1 cycles after rd_n or cs_n rises.
- Host strobes must be low for at least SYNC_STAGES+1 cycles and high for at least 2 cycles between strobes. dato must be stable for the whole low period of wr_n.
- Read data is a snapshot taken at entry to DRIVE. A tick during DRIVE does not change dato.
- Reset mid-read: dato releases on the clock after reset asserts.

## Structure
- Shared package rtc_bus_pkg:
  - register address constants ADDR_SEG=0x00, ADDR_MIN=0x01, ADDR_HORA=0x02;
  - FSM state enum {IDLE, DRIVE};
  - BCD limits 0x59 and 0x23.
- Sub-module bcd_inc: combinational, takes an 8-bit BCD value and an 8-bit limit, and returns next value and carry. One instance each for seconds, minutes and hours.
- The tri-state assignment lives only in the top level.

## Test plan
- Write/read: write address 0x05, then data 0xA7; read with a_d=1 -> dato=0xA7 after SYNC_STAGES+1 cycles, then high-Z after rd_n rises.
- Rollover: write 0x23/0x59/0x59 to registers 0x02/0x01/0x00, then pulse sec_tick -> out_hora/out_min/out_seg = 0x00/0x00/0x00.
- Collision: write 0x30 to 0x00 in the same cycle as sec_tick with seconds at 0x12 -> seconds=0x30.
- Illegal phases:
  - read with a_d=0 -> out_drive stays 0;
  - rd_n and wr_n low together -> no drive and all registers unchanged.
- Out of range: address 0x20 -> write ignored, read returns 0x00.
- Reset mid-read: assert reset during DRIVE -> dato high-Z and out_drive=0 on the next clock; all registers read 0x00 afterwards.
